decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
- Registered, parametrised one-hot decoder: SEL_W-bit index to NUM_OUT one-hot lines, with selectable output polarity.
- Two modes: direct decode of a host-supplied index, or autonomous scan that rotates the active line with a programmable dwell time.
- Used for display digit strobing, row/bank selection and chip-select fan-out.
- Replaces ad-hoc combinational decoders wherever glitch-free registered selects are needed.

Parameters:
SEL_W, 3, index width in bits.
NUM_OUT, 8, number of one-hot outputs; legal range 2..2**SEL_W.
DWELL_W, 8, width of the dwell-time input.
ACTIVE_LOW, 0, 1 = active line driven 0 and inactive lines driven 1.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  block enable; when low, all outputs are inactive.
mode  in  1  0 = DIRECT, 1 = SCAN; sampled every cycle.
sel_valid  in  1  qualifies sel for one cycle.
sel  in  SEL_W  requested index.
dwell  in  DWELL_W  SCAN mode: each line is active for dwell+1 cycles.
o  out  NUM_OUT  registered one-hot (or one-cold) select lines.
idx  out  SEL_W  registered current index.
wrap  out  1  one-cycle pulse when SCAN wraps from NUM_OUT-1 to 0.
err  out  1  one-cycle pulse when sel_valid is accepted with sel >= NUM_OUT.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, idx = 0, dwell counter = 0, wrap = 0, err = 0.
  - o = all-inactive: all 0s, or all 1s if ACTIVE_LOW.
- Inactive value: every output line at its inactive level. Active value: only bit idx at its active level.
- State machine (states IDLE, DIRECT, SCAN):
  - Any state with en=0: next state IDLE; o inactive next cycle; idx held; sel_valid ignored; wrap and err are 0.
  - IDLE with en=1: go to DIRECT if mode=0, or SCAN if mode=1. Load dwell counter with dwell. o becomes active for the held idx one cycle later.
  - DIRECT with mode=1: go to SCAN; idx kept; dwell counter loaded with dwell.
  - SCAN with mode=0: go to DIRECT; idx kept; dwell counter frozen.
- DIRECT:
  - sel_valid=1 and sel < NUM_OUT: idx <= sel; o shows onehot(sel) on the next cycle (1-cycle latency).
  - sel_valid=1 and sel >= NUM_OUT: idx and o unchanged; err=1 for one cycle.
  - No sel_valid: hold.
- SCAN:
  - Dwell counter decrements each cycle.
  - When the counter is 0: idx <= (idx == NUM_OUT-1) ? 0 : idx+1, and the counter reloads with the current dwell value (sampled at reload).
  - On the wrap step, wrap=1 in the same cycle that idx first reads 0.
  - dwell = 0 means the index advances every cycle.
  - sel_valid with legal sel overrides the step: idx <= sel, counter reloads, no wrap pulse.
  - sel_valid with illegal sel: err=1 and normal stepping continues.
- o is always registered from the next-state idx, so o and idx change in the same cycle. Exactly one line is active whenever state is not IDLE.
- Simultaneous events:
  - en=0 has priority over everything.
  - Legal sel_valid has priority over a scan step.
  - A mode change and sel_valid in the same cycle: sel is applied and the mode switches.
- Reset asserted mid-scan: outputs go inactive immediately; no wrap or err pulse is emitted.

Decomposition:
- Package decoder_pkg holds:
  - state enum type (IDLE, DIRECT, SCAN);
  - function onehot(idx, NUM_OUT, ACTIVE_LOW) returning the output vector;
  - localparam LAST = NUM_OUT-1.
- One natural sub-module: dwell_timer (load, decrement, zero flag, DWELL_W wide), instantiated once. The FSM and decode stay in the top level.

Test Plan:
- Reset, then en=1, mode=0, sel_valid pulse with sel=5 (defaults) -> one cycle later o=8'b0010_0000, idx=5; with ACTIVE_LOW=1, o=8'b1101_1111.
- DIRECT, sel=6 with NUM_OUT=6 -> err pulses once; o and idx keep their previous value.
- SCAN, dwell=2, starting at idx=0 -> idx steps 0,1,..,7 with each value held 3 cycles; wrap pulses exactly when idx returns to 0 (after 24 cycles).
- SCAN, dwell=0, NUM_OUT=5 -> idx 0,1,2,3,4,0 on consecutive cycles; wrap on the 6th cycle; o never has more than one active bit.
- SCAN mid-dwell, sel_valid with sel=3 in the same cycle the counter hits 0 -> idx=3 (no step to idx+1), full dwell restarts, no wrap.
- Toggle en low mid-scan, then high -> o inactive the cycle after en falls; idx held; on re-enable the scan resumes from the held idx with a fresh dwell. An async rst pulse mid-scan forces o inactive immediately.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder with scan mode.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam int MAX_OUT     = 256;
  localparam int DEF_NUM_OUT = 8;
  localparam int LAST        = DEF_NUM_OUT - 1;

  // Active value for index idx; bits at or above num_out are left 0 and are sliced off by the caller.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [7:0] idx, input int num_out,
                                                input logic active_low);
    logic [MAX_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (i < num_out) v[i] = active_low ? (idx != 8'(i)) : (idx == 8'(i));
    end
    return v;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that parks at zero; zero flags the end of a dwell period.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - DWELL_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot (or one-cold) decoder with direct index load and autonomous scan.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 8,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] o,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               err
);

  localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] O_IDLE   = ACTIVE_LOW ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   idx_reg, idx_next;
  logic [NUM_OUT-1:0] o_reg, o_next;
  logic               wrap_reg, wrap_next;
  logic               err_reg, err_next;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic               sel_legal;

  // When NUM_OUT fills the index space every sel is legal; avoid a constant compare.
  generate
    if (NUM_OUT >= (1 << SEL_W)) begin : g_full_range
      assign sel_legal = 1'b1;
    end else begin : g_part_range
      assign sel_legal = (sel < SEL_W'(NUM_OUT));
    end
  endgenerate

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (dwell),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wrap_next  = 1'b0;
    err_next   = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = mode ? SCAN : DIRECT;
          tmr_load   = 1'b1;
        end
        DIRECT: begin
          if (sel_valid) begin
            if (sel_legal) idx_next = sel;
            else           err_next = 1'b1;
          end
          if (mode) begin
            state_next = SCAN;
            tmr_load   = 1'b1;
          end
        end
        SCAN: begin
          if (sel_valid && !sel_legal) err_next = 1'b1;
          if (!mode) begin
            // Leaving scan freezes the counter; a legal sel still lands.
            state_next = DIRECT;
            if (sel_valid && sel_legal) idx_next = sel;
          end else if (sel_valid && sel_legal) begin
            idx_next = sel;
            tmr_load = 1'b1;
          end else if (tmr_zero) begin
            idx_next  = (idx_reg == LAST_SEL) ? '0 : idx_reg + SEL_W'(1);
            wrap_next = (idx_reg == LAST_SEL);
            tmr_load  = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    o_next = (state_next == IDLE) ? O_IDLE
                                  : NUM_OUT'(onehot(8'(idx_next), NUM_OUT, ACTIVE_LOW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      o_reg     <= O_IDLE;
      wrap_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      o_reg     <= o_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

  assign o    = o_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench: four decoder_scan configurations share one stimulus stream.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       sel_valid = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] dwell = '0;

  logic [7:0] o8, o8l;
  logic [5:0] o6;
  logic [4:0] o5;
  logic [2:0] idx8, idx8l, idx6, idx5;
  logic       wrap8, wrap8l, wrap6, wrap5;
  logic       err8, err8l, err6, err5;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_scan u_dut8 (.clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
                       .dwell(dwell), .o(o8), .idx(idx8), .wrap(wrap8), .err(err8));
  decoder_scan #(.ACTIVE_LOW(1'b1)) u_dut8l (.clk(clk), .rst(rst), .en(en), .mode(mode),
                       .sel_valid(sel_valid), .sel(sel), .dwell(dwell), .o(o8l), .idx(idx8l),
                       .wrap(wrap8l), .err(err8l));
  decoder_scan #(.NUM_OUT(6)) u_dut6 (.clk(clk), .rst(rst), .en(en), .mode(mode),
                       .sel_valid(sel_valid), .sel(sel), .dwell(dwell), .o(o6), .idx(idx6),
                       .wrap(wrap6), .err(err6));
  decoder_scan #(.NUM_OUT(5)) u_dut5 (.clk(clk), .rst(rst), .en(en), .mode(mode),
                       .sel_valid(sel_valid), .sel(sel), .dwell(dwell), .o(o5), .idx(idx5),
                       .wrap(wrap5), .err(err5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    $display("tx reset: o8=%b o8l=%b o6=%b o5=%b", o8, o8l, o6, o5);
    vecs++; if (o8 !== 8'h00) begin miscompares++; $display("FAIL reset_o8 got %b want 00000000", o8); end
    vecs++; if (o8l !== 8'hFF) begin miscompares++; $display("FAIL reset_o8l got %b want 11111111", o8l); end
    vecs++; if (o6 !== 6'h00 || o5 !== 5'h00) begin miscompares++; $display("FAIL reset_o65 got %b %b want 0", o6, o5); end
    vecs++; if ({idx8, idx8l, idx6, idx5} !== 12'h000) begin miscompares++; $display("FAIL reset_idx got %h want 000", {idx8, idx8l, idx6, idx5}); end
    vecs++; if ({wrap8, wrap8l, wrap6, wrap5, err8, err8l, err6, err5} !== 8'h00) begin
      miscompares++; $display("FAIL reset_pulses got %b want 00000000", {wrap8, wrap8l, wrap6, wrap5, err8, err8l, err6, err5});
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    en = 1'b1; mode = 1'b0;
    tick();
    vecs++; if (o8 !== 8'h01) begin miscompares++; $display("FAIL direct_enter_o8 got %b want 00000001", o8); end
    sel_valid = 1'b1; sel = 3'd5;
    tick();
    sel_valid = 1'b0;
    $display("tx direct sel=5: o8=%b o8l=%b o6=%b idx8=%0d", o8, o8l, o6, idx8);
    vecs++; if (o8 !== 8'b0010_0000) begin miscompares++; $display("FAIL direct_o8 got %b want 00100000", o8); end
    vecs++; if (idx8 !== 3'd5) begin miscompares++; $display("FAIL direct_idx8 got %0d want 5", idx8); end
    vecs++; if (o8l !== 8'b1101_1111) begin miscompares++; $display("FAIL direct_o8l got %b want 11011111", o8l); end
    vecs++; if (o6 !== 6'b10_0000) begin miscompares++; $display("FAIL direct_o6 got %b want 100000", o6); end
    tick();
    vecs++; if (o8 !== 8'b0010_0000) begin miscompares++; $display("FAIL direct_hold_o8 got %b want 00100000", o8); end
  endtask

  task automatic test_err();
    sel_valid = 1'b1; sel = 3'd6;
    tick();
    sel_valid = 1'b0;
    $display("tx direct sel=6: err6=%b idx6=%0d o6=%b idx8=%0d err8=%b", err6, idx6, o6, idx8, err8);
    vecs++; if (err6 !== 1'b1) begin miscompares++; $display("FAIL err6_pulse got %b want 1", err6); end
    vecs++; if (idx6 !== 3'd5) begin miscompares++; $display("FAIL err6_idx got %0d want 5", idx6); end
    vecs++; if (o6 !== 6'b10_0000) begin miscompares++; $display("FAIL err6_o got %b want 100000", o6); end
    vecs++; if (idx8 !== 3'd6 || err8 !== 1'b0) begin miscompares++; $display("FAIL err8_legal got idx %0d err %b want 6 0", idx8, err8); end
    tick();
    vecs++; if (err6 !== 1'b0) begin miscompares++; $display("FAIL err6_one_cycle got %b want 0", err6); end
  endtask

  task automatic test_mode_switch();
    // DIRECT at idx 6: switch to SCAN and load sel=2 in the same cycle.
    mode = 1'b1; sel_valid = 1'b1; sel = 3'd2; dwell = 8'd1;
    tick();
    sel_valid = 1'b0;
    $display("tx mode->scan sel=2: idx8=%0d", idx8);
    vecs++; if (idx8 !== 3'd2) begin miscompares++; $display("FAIL modesw_sel got %0d want 2", idx8); end
    tick();
    vecs++; if (idx8 !== 3'd2) begin miscompares++; $display("FAIL modesw_dwell got %0d want 2", idx8); end
    tick();
    vecs++; if (idx8 !== 3'd3) begin miscompares++; $display("FAIL modesw_step got %0d want 3", idx8); end
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++; if (idx8 !== 3'd3) begin miscompares++; $display("FAIL modesw_direct_hold k=%0d got %0d want 3", k, idx8); end
    end
  endtask

  task automatic test_scan_dwell2();
    logic [2:0] exp_idx;
    logic [7:0] one8;
    one8 = 8'd1;
    do_reset();
    en = 1'b1; mode = 1'b1; dwell = 8'd2;
    for (int k = 0; k <= 25; k++) begin
      tick();
      exp_idx = 3'((k / 3) % 8);
      $display("tx scan dwell=2 k=%0d: idx8=%0d wrap8=%b o8=%b", k, idx8, wrap8, o8);
      vecs++; if (idx8 !== exp_idx) begin miscompares++; $display("FAIL scan2_idx k=%0d got %0d want %0d", k, idx8, exp_idx); end
      vecs++; if (wrap8 !== (k == 24)) begin miscompares++; $display("FAIL scan2_wrap k=%0d got %b want %b", k, wrap8, (k == 24)); end
      vecs++; if (o8 !== (one8 << exp_idx)) begin miscompares++; $display("FAIL scan2_o k=%0d got %b want %b", k, o8, one8 << exp_idx); end
    end
  endtask

  task automatic test_scan_dwell0();
    logic [2:0] exp_idx;
    logic [4:0] one5;
    one5 = 5'd1;
    do_reset();
    en = 1'b1; mode = 1'b1; dwell = 8'd0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_idx = 3'(k % 5);
      $display("tx scan dwell=0 k=%0d: idx5=%0d wrap5=%b o5=%b", k, idx5, wrap5, o5);
      vecs++; if (idx5 !== exp_idx) begin miscompares++; $display("FAIL scan0_idx k=%0d got %0d want %0d", k, idx5, exp_idx); end
      vecs++; if (wrap5 !== (k == 5)) begin miscompares++; $display("FAIL scan0_wrap k=%0d got %b want %b", k, wrap5, (k == 5)); end
      vecs++; if (o5 !== (one5 << exp_idx) || $countones(o5) != 1) begin
        miscompares++; $display("FAIL scan0_o k=%0d got %b want %b", k, o5, one5 << exp_idx);
      end
      vecs++; if (err5 !== 1'b0) begin miscompares++; $display("FAIL scan0_err k=%0d got %b want 0", k, err5); end
    end
  endtask

  task automatic test_sel_override();
    do_reset();
    en = 1'b1; mode = 1'b1; dwell = 8'd2;
    tick(); tick(); tick();
    vecs++; if (idx8 !== 3'd0) begin miscompares++; $display("FAIL ovr_pre got %0d want 0", idx8); end
    // Counter is now 0: sel=3 must win over the step to 1.
    sel_valid = 1'b1; sel = 3'd3;
    tick();
    sel_valid = 1'b0;
    $display("tx scan override sel=3: idx8=%0d wrap8=%b", idx8, wrap8);
    vecs++; if (idx8 !== 3'd3) begin miscompares++; $display("FAIL ovr_idx got %0d want 3", idx8); end
    vecs++; if (wrap8 !== 1'b0) begin miscompares++; $display("FAIL ovr_wrap got %b want 0", wrap8); end
    tick();
    vecs++; if (idx8 !== 3'd3) begin miscompares++; $display("FAIL ovr_dwell1 got %0d want 3", idx8); end
    tick();
    vecs++; if (idx8 !== 3'd3) begin miscompares++; $display("FAIL ovr_dwell2 got %0d want 3", idx8); end
    tick();
    vecs++; if (idx8 !== 3'd4) begin miscompares++; $display("FAIL ovr_step got %0d want 4", idx8); end
  endtask

  task automatic test_enable_toggle();
    // Continues from idx 4 with a fresh dwell of 2.
    en = 1'b0; sel_valid = 1'b1; sel = 3'd7;
    tick();
    sel_valid = 1'b0;
    $display("tx en=0: o8=%b idx8=%0d err6=%b", o8, idx8, err6);
    vecs++; if (o8 !== 8'h00) begin miscompares++; $display("FAIL en0_o got %b want 00000000", o8); end
    vecs++; if (idx8 !== 3'd4) begin miscompares++; $display("FAIL en0_idx got %0d want 4", idx8); end
    vecs++; if (err6 !== 1'b0 || wrap8 !== 1'b0) begin miscompares++; $display("FAIL en0_pulses got err %b wrap %b want 0 0", err6, wrap8); end
    vecs++; if (o8l !== 8'hFF) begin miscompares++; $display("FAIL en0_o8l got %b want 11111111", o8l); end
    tick();
    en = 1'b1;
    tick();
    $display("tx en=1: o8=%b idx8=%0d", o8, idx8);
    vecs++; if (o8 !== 8'b0001_0000) begin miscompares++; $display("FAIL reen_o got %b want 00010000", o8); end
    tick(); tick();
    vecs++; if (idx8 !== 3'd4) begin miscompares++; $display("FAIL reen_dwell got %0d want 4", idx8); end
    tick();
    vecs++; if (idx8 !== 3'd5) begin miscompares++; $display("FAIL reen_step got %0d want 5", idx8); end
  endtask

  task automatic test_async_rst();
    do_reset();
    en = 1'b1; mode = 1'b1; dwell = 8'd2;
    tick(); tick(); tick(); tick();
    vecs++; if (idx8 !== 3'd1) begin miscompares++; $display("FAIL arst_pre got %0d want 1", idx8); end
    #2 rst = 1'b1;
    #1;
    $display("tx async rst: o8=%b o8l=%b idx8=%0d", o8, o8l, idx8);
    vecs++; if (o8 !== 8'h00) begin miscompares++; $display("FAIL arst_o8 got %b want 00000000", o8); end
    vecs++; if (o8l !== 8'hFF) begin miscompares++; $display("FAIL arst_o8l got %b want 11111111", o8l); end
    vecs++; if (idx8 !== 3'd0 || wrap8 !== 1'b0) begin miscompares++; $display("FAIL arst_state got idx %0d wrap %b want 0 0", idx8, wrap8); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_direct();
    test_err();
    test_mode_switch();
    test_scan_dwell2();
    test_scan_dwell0();
    test_sel_override();
    test_enable_toggle();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
